// File: rtl/mem_req_initiator_if.sv
// Memory-port bundle of the 128-bit core<->memory request/response protocol.
//   master : the initiator (drives the request pulse, receives the response)
//   slave  : the memory side (receives the request, drives the response)
// Signals
//   mem_req_valid       one-cycle request pulse
//   mem_req_addr        64-bit line address, low nibble always zero
//   mem_req_opcode      4-bit opcode (line load / line store)
//   mem_req_store_data  128-bit store data, zero for loads
//   mem_rsp_valid       response strobe, any cycle after the request pulse
//   mem_rsp_load_data   128-bit response data, valid with mem_rsp_valid
interface mem_req_initiator_if;
  logic         mem_req_valid;
  logic [63:0]  mem_req_addr;
  logic [3:0]   mem_req_opcode;
  logic [127:0] mem_req_store_data;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_load_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_opcode, mem_req_store_data,
    input  mem_rsp_valid, mem_rsp_load_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_opcode, mem_req_store_data,
    output mem_rsp_valid, mem_rsp_load_data
  );
endinterface

// File: rtl/mem_req_initiator.sv
// Initiator side of the core<->memory line protocol. Arbitrates line requests
// from L1I (loads only) and L1D (loads/stores) round-robin, issues one memory
// request at a time, waits for the response and returns data/ack to the winner.
// Ports
//   clk, reset            clock; synchronous active-low reset
//   l1i_req_*/l1i_rsp_*   L1I request (valid/addr/ready) and response (valid/data)
//   l1d_req_*/l1d_rsp_*   L1D request (valid/addr/store/store_data/ready) and response
//   mem                   memory-port bundle (master side)
//   busy                  transaction in flight
//   err_timeout           sticky: memory did not answer within TIMEOUT_CYCLES
//   l1i_reqs, l1d_reqs    wrapping counts of accepted requests per source
module mem_req_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [3:0]  OPC_LOAD       = 4'd4,
  parameter logic [3:0]  OPC_STORE      = 4'd7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                l1i_req_valid,
  input  logic [63:0]         l1i_req_addr,
  output logic                l1i_req_ready,
  output logic                l1i_rsp_valid,
  output logic [127:0]        l1i_rsp_data,
  input  logic                l1d_req_valid,
  input  logic [63:0]         l1d_req_addr,
  input  logic                l1d_req_store,
  input  logic [127:0]        l1d_req_store_data,
  output logic                l1d_req_ready,
  output logic                l1d_rsp_valid,
  output logic [127:0]        l1d_rsp_data,
  mem_req_initiator_if.master mem,
  output logic                busy,
  output logic                err_timeout,
  output logic [31:0]         l1i_reqs,
  output logic [31:0]         l1d_reqs
);

  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WAIT_LAST  = 32'(TIMEOUT_CYCLES) - 32'd1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic        src_d;       // current transaction belongs to L1D
  logic        src_st;      // current transaction is a store
  logic        last_d;      // source served last was L1D
  logic [31:0] wait_cnt;

  logic any_req;
  logic arb_last_d;
  logic win_d;
  logic win_st;
  logic unused_addr_lsbs;

  // Both valid -> the source not served last; otherwise whoever is asking.
  function automatic logic pick_d(input logic iv, input logic dv, input logic prev_d);
    return dv & (~iv | ~prev_d);
  endfunction

  // Line addresses drop the byte offset; those bits are intentionally ignored.
  assign unused_addr_lsbs = ^{l1i_req_addr[3:0], l1d_req_addr[3:0]};

  assign any_req = l1i_req_valid | l1d_req_valid;
  // RESP arbitrates for the next request itself, so the pointer it uses must
  // already reflect the transaction being completed in that cycle.
  assign arb_last_d = (state == S_RESP) ? src_d : last_d;
  assign win_d      = pick_d(l1i_req_valid, l1d_req_valid, arb_last_d);
  assign win_st     = win_d & l1d_req_store;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                  <= S_IDLE;
      src_d                  <= 1'b0;
      src_st                 <= 1'b0;
      last_d                 <= 1'b1;   // so that L1I wins the first tie
      wait_cnt               <= '0;
      l1i_req_ready          <= 1'b0;
      l1i_rsp_valid          <= 1'b0;
      l1i_rsp_data           <= '0;
      l1d_req_ready          <= 1'b0;
      l1d_rsp_valid          <= 1'b0;
      l1d_rsp_data           <= '0;
      mem.mem_req_valid      <= 1'b0;
      mem.mem_req_addr       <= '0;
      mem.mem_req_opcode     <= '0;
      mem.mem_req_store_data <= '0;
      busy                   <= 1'b0;
      err_timeout            <= 1'b0;
      l1i_reqs               <= '0;
      l1d_reqs               <= '0;
    end else begin
      l1i_req_ready     <= 1'b0;
      l1d_req_ready     <= 1'b0;
      l1i_rsp_valid     <= 1'b0;
      l1d_rsp_valid     <= 1'b0;
      mem.mem_req_valid <= 1'b0;

      case (state)
        // RESP completes the old transaction and, like IDLE, may accept the
        // next one in the same cycle; this keeps accept-to-accept at 4 cycles.
        S_IDLE, S_RESP: begin
          if (state == S_RESP) last_d <= src_d;
          if (any_req) begin
            src_d                  <= win_d;
            src_st                 <= win_st;
            l1i_req_ready          <= ~win_d;
            l1d_req_ready          <= win_d;
            mem.mem_req_addr       <= win_d ? {l1d_req_addr[63:4], 4'b0}
                                            : {l1i_req_addr[63:4], 4'b0};
            mem.mem_req_opcode     <= win_st ? OPC_STORE : OPC_LOAD;
            mem.mem_req_store_data <= win_st ? l1d_req_store_data : '0;
            if (win_d) l1d_reqs <= l1d_reqs + 32'd1;
            else       l1i_reqs <= l1i_reqs + 32'd1;
            busy  <= 1'b1;
            state <= S_ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_ISSUE: begin
          mem.mem_req_valid <= 1'b1;
          wait_cnt          <= '0;
          state             <= S_WAIT;
        end

        S_WAIT: begin
          // The first WAIT cycle is the request pulse itself; a response is
          // only legal, and only counted toward the timeout, after it.
          if (!mem.mem_req_valid) begin
            if (mem.mem_rsp_valid) begin
              if (src_d) begin
                l1d_rsp_valid <= 1'b1;
                l1d_rsp_data  <= src_st ? '0 : mem.mem_rsp_load_data;
              end else begin
                l1i_rsp_valid <= 1'b1;
                l1i_rsp_data  <= mem.mem_rsp_load_data;
              end
              state <= S_RESP;
            end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
              err_timeout <= 1'b1;
              busy        <= 1'b0;
              state       <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + 32'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_initiator.sv
module tb_mem_req_initiator;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         l1i_req_valid = 1'b0;
  logic [63:0]  l1i_req_addr = '0;
  logic         l1i_req_ready, l1i_rsp_valid;
  logic [127:0] l1i_rsp_data;
  logic         l1d_req_valid = 1'b0;
  logic [63:0]  l1d_req_addr = '0;
  logic         l1d_req_store = 1'b0;
  logic [127:0] l1d_req_store_data = '0;
  logic         l1d_req_ready, l1d_rsp_valid;
  logic [127:0] l1d_rsp_data;
  logic         busy, err_timeout;
  logic [31:0]  l1i_reqs, l1d_reqs;

  mem_req_initiator_if mem_if();

  mem_req_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .l1i_req_valid(l1i_req_valid), .l1i_req_addr(l1i_req_addr),
    .l1i_req_ready(l1i_req_ready), .l1i_rsp_valid(l1i_rsp_valid),
    .l1i_rsp_data(l1i_rsp_data),
    .l1d_req_valid(l1d_req_valid), .l1d_req_addr(l1d_req_addr),
    .l1d_req_store(l1d_req_store), .l1d_req_store_data(l1d_req_store_data),
    .l1d_req_ready(l1d_req_ready), .l1d_rsp_valid(l1d_rsp_valid),
    .l1d_rsp_data(l1d_rsp_data),
    .mem(mem_if.master),
    .busy(busy), .err_timeout(err_timeout),
    .l1i_reqs(l1i_reqs), .l1d_reqs(l1d_reqs)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  bit          last_d;            // source that completed last (1 = L1D)
  logic [31:0] exp_icnt, exp_dcnt;

  task automatic model_reset();
    last_d   = 1'b1;
    exp_icnt = '0;
    exp_dcnt = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_i_ready"},   l1i_req_ready, 0);
    check({tag, "_d_ready"},   l1d_req_ready, 0);
    check({tag, "_i_rsp"},     l1i_rsp_valid, 0);
    check({tag, "_d_rsp"},     l1d_rsp_valid, 0);
    check({tag, "_mem_valid"}, mem_if.mem_req_valid, 0);
    check({tag, "_busy"},      busy, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_quiet(tag);
    check({tag, "_err"},    err_timeout, 0);
    check({tag, "_i_cnt"},  l1i_reqs, 0);
    check({tag, "_d_cnt"},  l1d_reqs, 0);
    check({tag, "_addr"},   mem_if.mem_req_addr, 0);
    check({tag, "_opc"},    mem_if.mem_req_opcode, 0);
    check({tag, "_i_data"}, l1i_rsp_data, 0);
    check({tag, "_d_data"}, l1d_rsp_data, 0);
  endtask

  task automatic clear_inputs();
    l1i_req_valid = 1'b0;
    l1d_req_valid = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_load_data = '0;
  endtask

  // One isolated transaction; memory answers 'delay' cycles after the pulse.
  task automatic directed_txn(input bit d, input logic [63:0] addr, input bit st,
                              input logic [127:0] sd, input int delay,
                              input logic [127:0] rdata, input string tag);
    logic [3:0]   e_opc;
    logic [127:0] e_sd, e_rsp;
    e_opc = (d && st) ? 4'd7 : 4'd4;
    e_sd  = (d && st) ? sd : '0;
    e_rsp = (d && st) ? '0 : rdata;
    if (d) begin
      l1d_req_valid = 1'b1; l1d_req_addr = addr;
      l1d_req_store = st;   l1d_req_store_data = sd;
    end else begin
      l1i_req_valid = 1'b1; l1i_req_addr = addr;
    end
    tick();
    check({tag, "_ready"}, d ? l1d_req_ready : l1i_req_ready, 1);
    check({tag, "_other_ready"}, d ? l1i_req_ready : l1d_req_ready, 0);
    if (d) exp_dcnt++; else exp_icnt++;
    check({tag, "_count"}, d ? l1d_reqs : l1i_reqs, d ? exp_dcnt : exp_icnt);
    check({tag, "_busy"}, busy, 1);
    l1i_req_valid = 1'b0;
    l1d_req_valid = 1'b0;
    tick();
    check({tag, "_pulse"}, mem_if.mem_req_valid, 1);
    check({tag, "_addr"},  mem_if.mem_req_addr, {addr[63:4], 4'h0});
    check({tag, "_opc"},   mem_if.mem_req_opcode, e_opc);
    check({tag, "_sdata"}, mem_if.mem_req_store_data, e_sd);
    for (int k = 1; k <= delay; k++) begin
      tick();
      if (k == 1) check({tag, "_pulse_len"}, mem_if.mem_req_valid, 0);
      check({tag, "_early_rsp"}, d ? l1d_rsp_valid : l1i_rsp_valid, 0);
      if (k == delay) begin
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_load_data = rdata;
      end
    end
    tick();
    mem_if.mem_rsp_valid = 1'b0;
    check({tag, "_rsp"},      d ? l1d_rsp_valid : l1i_rsp_valid, 1);
    check({tag, "_rsp_data"}, d ? l1d_rsp_data : l1i_rsp_data, e_rsp);
    check({tag, "_rsp_other"}, d ? l1i_rsp_valid : l1d_rsp_valid, 0);
    last_d = d;
    tick();
    check({tag, "_rsp_len"}, d ? l1d_rsp_valid : l1i_rsp_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  // Randomized traffic against the transaction-level model.
  bit           e_rdy_i, e_rdy_d, e_pulse, e_rsp_i, e_rsp_d;
  logic [127:0] e_rsp_data;
  bit           outst, iwait, dwait, cur_d, cur_st;
  logic [63:0]  cur_addr;
  logic [127:0] cur_sd;
  int           rsp_timer, accepts;
  bit           served_q[$];

  task automatic run_engine(input int target, input bit both, input int maxlat, input string tag);
    bit           any_rdy, n_rsp_i, n_rsp_d;
    logic [127:0] n_data;
    int           cyc;
    e_rdy_i = 0; e_rdy_d = 0; e_pulse = 0; e_rsp_i = 0; e_rsp_d = 0; e_rsp_data = '0;
    outst = 0; iwait = 0; dwait = 0; rsp_timer = 0; accepts = 0; cyc = 0;
    served_q.delete();
    while (cyc < 4000) begin
      cyc++;
      tick();
      check({tag, "_ready_i"}, l1i_req_ready, e_rdy_i);
      check({tag, "_ready_d"}, l1d_req_ready, e_rdy_d);
      check({tag, "_pulse"},   mem_if.mem_req_valid, e_pulse);
      if (e_pulse) begin
        check({tag, "_addr"},  mem_if.mem_req_addr, {cur_addr[63:4], 4'h0});
        check({tag, "_opc"},   mem_if.mem_req_opcode, cur_st ? 4'd7 : 4'd4);
        check({tag, "_sdata"}, mem_if.mem_req_store_data, cur_st ? cur_sd : 128'd0);
      end
      check({tag, "_rsp_i"}, l1i_rsp_valid, e_rsp_i);
      check({tag, "_rsp_d"}, l1d_rsp_valid, e_rsp_d);
      if (e_rsp_i) check({tag, "_rsp_i_data"}, l1i_rsp_data, e_rsp_data);
      if (e_rsp_d) check({tag, "_rsp_d_data"}, l1d_rsp_data, e_rsp_data);

      any_rdy = e_rdy_i || e_rdy_d;
      if (any_rdy) begin
        cur_d = e_rdy_d; outst = 1; accepts++;
        served_q.push_back(cur_d);
        if (cur_d) begin
          cur_addr = l1d_req_addr; cur_st = l1d_req_store; cur_sd = l1d_req_store_data;
          exp_dcnt++; dwait = 1; l1d_req_valid = 1'b0;
          check({tag, "_d_count"}, l1d_reqs, exp_dcnt);
        end else begin
          cur_addr = l1i_req_addr; cur_st = 0; cur_sd = '0;
          exp_icnt++; iwait = 1; l1i_req_valid = 1'b0;
          check({tag, "_i_count"}, l1i_reqs, exp_icnt);
        end
      end
      if (e_pulse) rsp_timer = $urandom_range(1, maxlat) + 1;
      if (e_rsp_i || e_rsp_d) begin
        last_d = e_rsp_d; outst = 0;
        if (e_rsp_d) dwait = 0; else iwait = 0;
      end

      mem_if.mem_rsp_valid = 1'b0;
      mem_if.mem_rsp_load_data = {$urandom, $urandom, $urandom, $urandom};
      n_rsp_i = 0; n_rsp_d = 0; n_data = '0;
      if (rsp_timer > 0) begin
        rsp_timer--;
        if (rsp_timer == 0) begin
          mem_if.mem_rsp_valid = 1'b1;
          n_rsp_d = cur_d; n_rsp_i = !cur_d;
          n_data  = cur_st ? 128'd0 : mem_if.mem_rsp_load_data;
        end
      end else if (!outst && $urandom_range(0, 5) == 0) begin
        mem_if.mem_rsp_valid = 1'b1;   // stray response, must be ignored
      end
      if (!l1i_req_valid && !iwait && accepts < target && (both || $urandom_range(0, 2) == 0)) begin
        l1i_req_valid = 1'b1;
        l1i_req_addr  = {$urandom, $urandom};
      end
      if (!l1d_req_valid && !dwait && accepts < target && (both || $urandom_range(0, 2) == 0)) begin
        l1d_req_valid      = 1'b1;
        l1d_req_addr       = {$urandom, $urandom};
        l1d_req_store      = 1'($urandom_range(0, 1));
        l1d_req_store_data = {$urandom, $urandom, $urandom, $urandom};
      end

      e_pulse = any_rdy; e_rsp_i = n_rsp_i; e_rsp_d = n_rsp_d; e_rsp_data = n_data;
      e_rdy_i = 0; e_rdy_d = 0;
      if (!outst && (l1i_req_valid || l1d_req_valid)) begin
        if (l1i_req_valid && l1d_req_valid) e_rdy_d = !last_d;
        else                                e_rdy_d = l1d_req_valid;
        e_rdy_i = !e_rdy_d;
      end
      if (accepts >= target && !outst && !l1i_req_valid && !l1d_req_valid) break;
    end
    check({tag, "_completed"}, accepts >= target, 1);
    tick();
    mem_if.mem_rsp_valid = 1'b0;
    check_quiet({tag, "_end"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    clear_inputs();
    model_reset();
    tick(); tick();
    check_reset_state("reset");
    reset = 1'b1;
    tick();
    check_quiet("post_reset");

    // L1I line load, memory answers 3 cycles after the pulse
    directed_txn(0, 64'h1008, 0, '0, 3, {4{32'hAAAA_AAAA}}, "t1");
    check("t1_icnt", l1i_reqs, 1);
    // L1D line store: opcode 7, data acknowledged as zero
    directed_txn(1, 64'h2000, 1, 128'h1234, 2, {4{32'h5555_5555}}, "t2");
    // Response on the cycle the timeout counter hits its limit wins
    directed_txn(1, 64'h3004, 0, '0, 16, {4{32'hC0DE_F00D}}, "limit");
    check("limit_no_err", err_timeout, 0);

    // Both sources valid continuously: strict alternation starting with L1I
    run_engine(6, 1, 1, "t3");
    check("t3_served", served_q.size() >= 6, 1);
    for (int i = 0; i < 6; i++) check($sformatf("t3_order%0d", i), served_q[i], i % 2);

    run_engine(60, 0, 5, "rand");

    // No memory response: timeout after 16 cycles in WAIT
    pulses = 0;
    l1i_req_valid = 1'b1; l1i_req_addr = 64'h4000;
    tick();
    check("t4_ready", l1i_req_ready, 1);
    exp_icnt++;
    l1i_req_valid = 1'b0;
    tick();
    check("t4_pulse", mem_if.mem_req_valid, 1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (l1i_rsp_valid || l1d_rsp_valid) pulses++;
    end
    check("t4_err_early", err_timeout, 0);
    check("t4_busy_early", busy, 1);
    tick();
    check("t4_err", err_timeout, 1);
    check("t4_idle", busy, 0);
    if (l1i_rsp_valid || l1d_rsp_valid) pulses++;
    tick();
    check("t4_no_rsp", pulses, 0);
    directed_txn(0, 64'h4010, 0, '0, 2, {4{32'h1357_9BDF}}, "t4_after");
    check("t4_err_sticky", err_timeout, 1);

    // Stray responses while idle produce nothing
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_load_data = {4{32'hDEAD_BEEF}};
    for (int k = 0; k < 3; k++) begin
      tick();
      check_quiet($sformatf("t5_stray%0d", k));
    end
    mem_if.mem_rsp_valid = 1'b0;
    // Reset during WAIT abandons the transaction
    l1d_req_valid = 1'b1; l1d_req_addr = 64'h5000; l1d_req_store = 1'b0;
    tick();
    check("t5_ready", l1d_req_ready, 1);
    l1d_req_valid = 1'b0;
    tick();
    check("t5_pulse", mem_if.mem_req_valid, 1);
    tick();
    reset = 1'b0;
    tick();
    model_reset();
    check_reset_state("t5_reset");
    reset = 1'b1;
    tick();
    check("t5_no_pulse", mem_if.mem_req_valid, 0);
    mem_if.mem_rsp_valid = 1'b1;
    tick();
    mem_if.mem_rsp_valid = 1'b0;
    tick();
    check_quiet("t5_late_rsp");

    // Counter wrap
    force dut.l1d_reqs = 32'hFFFF_FFFF;
    tick();
    release dut.l1d_reqs;
    tick();
    check("t6_preload", l1d_reqs, 32'hFFFF_FFFF);
    exp_dcnt = 32'hFFFF_FFFF;
    directed_txn(1, 64'h6000, 0, '0, 1, {4{32'h2468_ACE0}}, "t6");
    check("t6_wrapped", l1d_reqs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
